// File: rtl/acc_demo_flag_phase_monitor_if.sv
// Trim ctrl/flag observation bus between the trim path and the phase monitor.
// The master side drives the scan enable, the flag pair and the expected times; the slave returns the measurements.
interface acc_demo_flag_phase_monitor_if #(
    parameter int CNT_W  = 16,
    parameter int STAT_W = 16
);
    logic              pmt_scan_en_i;
    logic              acc_demo_trim_ctrl_i;
    logic              acc_demo_trim_flag_i;
    logic [CNT_W-1:0]  acc_demo_trim_time_pose_i;
    logic [CNT_W-1:0]  acc_demo_trim_time_nege_i;
    logic [CNT_W-1:0]  pose_delay_o;
    logic [CNT_W-1:0]  nege_delay_o;
    logic              meas_valid_o;
    logic [STAT_W-1:0] pulse_cnt_o;
    logic [STAT_W-1:0] err_cnt_o;
    logic              err_flag_o;

    modport master (
        output pmt_scan_en_i, acc_demo_trim_ctrl_i, acc_demo_trim_flag_i,
               acc_demo_trim_time_pose_i, acc_demo_trim_time_nege_i,
        input  pose_delay_o, nege_delay_o, meas_valid_o, pulse_cnt_o, err_cnt_o, err_flag_o
    );

    modport slave (
        input  pmt_scan_en_i, acc_demo_trim_ctrl_i, acc_demo_trim_flag_i,
               acc_demo_trim_time_pose_i, acc_demo_trim_time_nege_i,
        output pose_delay_o, nege_delay_o, meas_valid_o, pulse_cnt_o, err_cnt_o, err_flag_o
    );
endinterface

// File: rtl/acc_demo_flag_phase_monitor.sv
// Trim flag phase monitor: measures ctrl->flag rise and fall delays per pulse,
// checks them against the programmed trim times and keeps per-scan pulse/error statistics.
module acc_demo_flag_phase_monitor_ch #(
    parameter int CNT_W = 16,
    parameter int TOL   = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_active,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [CNT_W-1:0] i_expect,
    output logic             o_rec,
    output logic [CNT_W-1:0] o_rec_val,
    output logic             o_err
);
    typedef enum logic {ST_IDLE, ST_ARMED} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_elapsed;
    logic [CNT_W:0]   w_diff;
    logic             w_seq_err;
    logic             w_timeout;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // r_cnt holds cycles since start minus one, so the stop-cycle delay is r_cnt + 1
    assign w_elapsed = r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_rec       = 1'b0;
        o_rec_val   = w_elapsed;
        w_seq_err   = 1'b0;
        w_timeout   = 1'b0;
        if (!i_active) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start && i_stop) begin
                        o_rec     = 1'b1;
                        o_rec_val = '0;
                    end else if (i_start) begin
                        w_state_nxt = ST_ARMED;
                        w_cnt_nxt   = '0;
                    end else if (i_stop) begin
                        w_seq_err = 1'b1;
                    end
                end
                ST_ARMED: begin
                    w_cnt_nxt = w_elapsed;
                    if (i_stop) begin
                        o_rec = 1'b1;
                        if (i_start) w_cnt_nxt   = '0;
                        else         w_state_nxt = ST_IDLE;
                    end else if (i_start) begin
                        w_seq_err = 1'b1;
                        w_cnt_nxt = '0;
                    end else if (&w_elapsed) begin
                        o_rec       = 1'b1;
                        w_timeout   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_diff = (o_rec_val >= i_expect) ? ({1'b0, o_rec_val} - {1'b0, i_expect})
                                            : ({1'b0, i_expect} - {1'b0, o_rec_val});

    // A timeout already counts as the error for its record
    assign o_err = w_seq_err | w_timeout |
                   (o_rec & ~w_timeout & (w_diff > (CNT_W+1)'(TOL)));
endmodule

module acc_demo_flag_phase_monitor #(
    parameter int CNT_W  = 16,
    parameter int TOL    = 2,
    parameter int STAT_W = 16
) (
    input logic clk_i,
    input logic rst_i,
    acc_demo_flag_phase_monitor_if.slave bus
);
    logic              r_ctrl_d;
    logic              r_flag_d;
    logic              r_scan_d;
    logic [CNT_W-1:0]  r_pose_delay;
    logic [CNT_W-1:0]  r_nege_delay;
    logic              r_meas_valid;
    logic [STAT_W-1:0] r_pulse_cnt;
    logic [STAT_W-1:0] r_err_cnt;
    logic              r_err_flag;

    logic              w_scan_rise;
    logic              w_active;
    logic              w_p_rec;
    logic              w_p_err;
    logic              w_n_rec;
    logic              w_n_err;
    logic [CNT_W-1:0]  w_p_val;
    logic [CNT_W-1:0]  w_n_val;
    logic [STAT_W:0]   w_pulse_sum;
    logic [STAT_W:0]   w_err_sum;
    logic [STAT_W-1:0] w_pulse_nxt;
    logic [STAT_W-1:0] w_err_nxt;

    assign w_scan_rise = bus.pmt_scan_en_i & ~r_scan_d;
    assign w_active    = bus.pmt_scan_en_i & ~w_scan_rise;

    acc_demo_flag_phase_monitor_ch #(.CNT_W(CNT_W), .TOL(TOL)) u_pose_ch (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_active  (w_active),
        .i_start   (bus.acc_demo_trim_ctrl_i & ~r_ctrl_d),
        .i_stop    (bus.acc_demo_trim_flag_i & ~r_flag_d),
        .i_expect  (bus.acc_demo_trim_time_pose_i),
        .o_rec     (w_p_rec),
        .o_rec_val (w_p_val),
        .o_err     (w_p_err)
    );

    acc_demo_flag_phase_monitor_ch #(.CNT_W(CNT_W), .TOL(TOL)) u_nege_ch (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_active  (w_active),
        .i_start   (~bus.acc_demo_trim_ctrl_i & r_ctrl_d),
        .i_stop    (~bus.acc_demo_trim_flag_i & r_flag_d),
        .i_expect  (bus.acc_demo_trim_time_nege_i),
        .o_rec     (w_n_rec),
        .o_rec_val (w_n_val),
        .o_err     (w_n_err)
    );

    always_comb begin
        w_pulse_sum = {1'b0, r_pulse_cnt} + (STAT_W+1)'(w_n_rec);
        w_err_sum   = {1'b0, r_err_cnt} + (STAT_W+1)'(w_p_err) + (STAT_W+1)'(w_n_err);
        w_pulse_nxt = w_pulse_sum[STAT_W] ? '1 : w_pulse_sum[STAT_W-1:0];
        w_err_nxt   = w_err_sum[STAT_W]   ? '1 : w_err_sum[STAT_W-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ctrl_d     <= 1'b0;
            r_flag_d     <= 1'b0;
            r_scan_d     <= 1'b0;
            r_pose_delay <= '0;
            r_nege_delay <= '0;
            r_meas_valid <= 1'b0;
            r_pulse_cnt  <= '0;
            r_err_cnt    <= '0;
            r_err_flag   <= 1'b0;
        end else begin
            r_ctrl_d <= bus.acc_demo_trim_ctrl_i;
            r_flag_d <= bus.acc_demo_trim_flag_i;
            r_scan_d <= bus.pmt_scan_en_i;
            if (w_scan_rise) begin
                r_pose_delay <= '0;
                r_nege_delay <= '0;
                r_meas_valid <= 1'b0;
                r_pulse_cnt  <= '0;
                r_err_cnt    <= '0;
                r_err_flag   <= 1'b0;
            end else begin
                r_meas_valid <= w_n_rec;
                if (w_p_rec) r_pose_delay <= w_p_val;
                if (w_n_rec) begin
                    r_nege_delay <= w_n_val;
                    r_pulse_cnt  <= w_pulse_nxt;
                end
                if (w_p_err || w_n_err) begin
                    r_err_cnt  <= w_err_nxt;
                    r_err_flag <= 1'b1;
                end
            end
        end
    end

    assign bus.pose_delay_o = r_pose_delay;
    assign bus.nege_delay_o = r_nege_delay;
    assign bus.meas_valid_o = r_meas_valid;
    assign bus.pulse_cnt_o  = r_pulse_cnt;
    assign bus.err_cnt_o    = r_err_cnt;
    assign bus.err_flag_o   = r_err_flag;
endmodule

// File: tb/tb_acc_demo_flag_phase_monitor.sv
// Bench for the trim flag phase monitor: a 16/16 instance for the main checks and a
// 4-bit/4-bit instance sharing the same stimulus for timeout and saturation corners.
module tb_acc_demo_flag_phase_monitor;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   mv_cnt = 0;

    always #5 clk = ~clk;

    acc_demo_flag_phase_monitor_if #(.CNT_W(16), .STAT_W(16)) bus ();
    acc_demo_flag_phase_monitor_if #(.CNT_W(4),  .STAT_W(4))  bus_s ();

    assign bus_s.pmt_scan_en_i             = bus.pmt_scan_en_i;
    assign bus_s.acc_demo_trim_ctrl_i      = bus.acc_demo_trim_ctrl_i;
    assign bus_s.acc_demo_trim_flag_i      = bus.acc_demo_trim_flag_i;
    assign bus_s.acc_demo_trim_time_pose_i = bus.acc_demo_trim_time_pose_i[3:0];
    assign bus_s.acc_demo_trim_time_nege_i = bus.acc_demo_trim_time_nege_i[3:0];

    acc_demo_flag_phase_monitor #(.CNT_W(16), .TOL(2), .STAT_W(16)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    acc_demo_flag_phase_monitor #(.CNT_W(4), .TOL(2), .STAT_W(4)) u_dut_s (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_s)
    );

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.meas_valid_o === 1'b1) mv_cnt++;
    endtask

    task automatic drive(input logic c, input logic f);
        bus.acc_demo_trim_ctrl_i = c;
        bus.acc_demo_trim_flag_i = f;
        step();
    endtask

    task automatic set_exp(input int ep, input int en);
        bus.acc_demo_trim_time_pose_i = 16'(ep);
        bus.acc_demo_trim_time_nege_i = 16'(en);
    endtask

    task automatic scan_restart();
        bus.pmt_scan_en_i = 1'b0;
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        bus.pmt_scan_en_i = 1'b1;
        drive(1'b0, 1'b0);
        mv_cnt = 0;
    endtask

    // ctrl high for h cycles; flag rises dp after ctrl rise and falls dn after ctrl fall
    task automatic pulse(input int dp, input int h, input int dn);
        for (int k = 0; k < h + dn + 3; k++)
            drive(logic'(k < h), logic'(k >= dp && k < h + dn));
    endtask

    task automatic test_reset();
        checks++; if (bus.pose_delay_o !== 16'd0) begin errors++; $display("FAIL reset_pose: got %0d expected 0", bus.pose_delay_o); end
        checks++; if (bus.nege_delay_o !== 16'd0) begin errors++; $display("FAIL reset_nege: got %0d expected 0", bus.nege_delay_o); end
        checks++; if (bus.meas_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", bus.meas_valid_o); end
        checks++; if (bus.pulse_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_pulse: got %0d expected 0", bus.pulse_cnt_o); end
        checks++; if (bus.err_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", bus.err_cnt_o); end
        checks++; if (bus.err_flag_o !== 1'b0) begin errors++; $display("FAIL reset_flag: got %0b expected 0", bus.err_flag_o); end
    endtask

    task automatic test_nominal();
        scan_restart();
        set_exp(5, 3);
        pulse(5, 20, 3);
        checks++; if (bus.pose_delay_o !== 16'd5) begin errors++; $display("FAIL nominal_pose: got %0d expected 5", bus.pose_delay_o); end
        checks++; if (bus.nege_delay_o !== 16'd3) begin errors++; $display("FAIL nominal_nege: got %0d expected 3", bus.nege_delay_o); end
        checks++; if (mv_cnt !== 1) begin errors++; $display("FAIL nominal_valid_pulses: got %0d expected 1", mv_cnt); end
        checks++; if (bus.pulse_cnt_o !== 16'd1) begin errors++; $display("FAIL nominal_pulse: got %0d expected 1", bus.pulse_cnt_o); end
        checks++; if (bus.err_cnt_o !== 16'd0) begin errors++; $display("FAIL nominal_err: got %0d expected 0", bus.err_cnt_o); end
        checks++; if (bus.err_flag_o !== 1'b0) begin errors++; $display("FAIL nominal_flag: got %0b expected 0", bus.err_flag_o); end
    endtask

    task automatic test_tolerance();
        pulse(9, 20, 3);
        checks++; if (bus.pose_delay_o !== 16'd9) begin errors++; $display("FAIL tol_pose9: got %0d expected 9", bus.pose_delay_o); end
        checks++; if (bus.err_cnt_o !== 16'd1) begin errors++; $display("FAIL tol_err9: got %0d expected 1", bus.err_cnt_o); end
        checks++; if (bus.err_flag_o !== 1'b1) begin errors++; $display("FAIL tol_flag9: got %0b expected 1", bus.err_flag_o); end
        pulse(7, 20, 3);
        checks++; if (bus.pose_delay_o !== 16'd7) begin errors++; $display("FAIL tol_pose7: got %0d expected 7", bus.pose_delay_o); end
        checks++; if (bus.err_cnt_o !== 16'd1) begin errors++; $display("FAIL tol_err7: got %0d expected 1", bus.err_cnt_o); end
        checks++; if (bus.pulse_cnt_o !== 16'd3) begin errors++; $display("FAIL tol_pulse: got %0d expected 3", bus.pulse_cnt_o); end
    endtask

    task automatic test_same_cycle();
        set_exp(0, 3);
        pulse(0, 6, 3);
        checks++; if (bus.pose_delay_o !== 16'd0) begin errors++; $display("FAIL same_pose: got %0d expected 0", bus.pose_delay_o); end
        checks++; if (bus.err_cnt_o !== 16'd1) begin errors++; $display("FAIL same_err: got %0d expected 1", bus.err_cnt_o); end
        checks++; if (bus.pulse_cnt_o !== 16'd4) begin errors++; $display("FAIL same_pulse: got %0d expected 4", bus.pulse_cnt_o); end
    endtask

    task automatic test_spurious_and_restart();
        logic [12:0] cs;
        logic [12:0] fs;
        scan_restart();
        set_exp(3, 2);
        drive(1'b0, 1'b1);
        checks++; if (bus.err_cnt_o !== 16'd1) begin errors++; $display("FAIL spur_rise_err: got %0d expected 1", bus.err_cnt_o); end
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        checks++; if (bus.err_cnt_o !== 16'd2) begin errors++; $display("FAIL spur_fall_err: got %0d expected 2", bus.err_cnt_o); end
        checks++; if (mv_cnt !== 0) begin errors++; $display("FAIL spur_valid: got %0d expected 0", mv_cnt); end
        // ctrl 1 1 0 0 1 1 1 1 1 1 0 0 0, flag high k7..k11: second ctrl rise at k4 (P missed),
        // ctrl fall at k10 while N still armed from k2 (N missed); pose=7-4=3, nege=12-10=2
        cs = 13'b0001111110011;
        fs = 13'b0111110000000;
        for (int k = 0; k < 13; k++) drive(cs[k], fs[k]);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0);
        checks++; if (bus.pose_delay_o !== 16'd3) begin errors++; $display("FAIL rearm_pose: got %0d expected 3", bus.pose_delay_o); end
        checks++; if (bus.nege_delay_o !== 16'd2) begin errors++; $display("FAIL rearm_nege: got %0d expected 2", bus.nege_delay_o); end
        checks++; if (bus.err_cnt_o !== 16'd4) begin errors++; $display("FAIL rearm_err: got %0d expected 4", bus.err_cnt_o); end
        checks++; if (mv_cnt !== 1) begin errors++; $display("FAIL rearm_valid: got %0d expected 1", mv_cnt); end
    endtask

    task automatic test_timeout();
        scan_restart();
        set_exp(5, 3);
        for (int k = 0; k < 30; k++) drive(1'b1, 1'b0);
        checks++; if (bus_s.pose_delay_o !== 4'd15) begin errors++; $display("FAIL tmo_pose: got %0d expected 15", bus_s.pose_delay_o); end
        checks++; if (bus_s.err_cnt_o !== 4'd1) begin errors++; $display("FAIL tmo_err: got %0d expected 1", bus_s.err_cnt_o); end
        for (int k = 0; k < 20; k++) drive(1'b0, 1'b0);
        checks++; if (bus_s.nege_delay_o !== 4'd15) begin errors++; $display("FAIL tmo_nege: got %0d expected 15", bus_s.nege_delay_o); end
        checks++; if (bus_s.pulse_cnt_o !== 4'd1) begin errors++; $display("FAIL tmo_pulse: got %0d expected 1", bus_s.pulse_cnt_o); end
        set_exp(4, 2);
        pulse(4, 6, 2);
        checks++; if (bus_s.pose_delay_o !== 4'd4) begin errors++; $display("FAIL tmo_next_pose: got %0d expected 4", bus_s.pose_delay_o); end
        checks++; if (bus_s.nege_delay_o !== 4'd2) begin errors++; $display("FAIL tmo_next_nege: got %0d expected 2", bus_s.nege_delay_o); end
        checks++; if (bus_s.err_cnt_o !== 4'd2) begin errors++; $display("FAIL tmo_next_err: got %0d expected 2", bus_s.err_cnt_o); end
    endtask

    task automatic test_saturation();
        scan_restart();
        set_exp(1, 1);
        for (int i = 0; i < 20; i++) pulse(1, 3, 1);
        checks++; if (bus_s.pulse_cnt_o !== 4'd15) begin errors++; $display("FAIL sat_pulse_s: got %0d expected 15", bus_s.pulse_cnt_o); end
        checks++; if (bus.pulse_cnt_o !== 16'd20) begin errors++; $display("FAIL sat_pulse: got %0d expected 20", bus.pulse_cnt_o); end
        checks++; if (bus_s.err_cnt_o !== 4'd0) begin errors++; $display("FAIL sat_err0_s: got %0d expected 0", bus_s.err_cnt_o); end
        // each bare flag pulse is a spurious rise and a spurious fall
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1);
            drive(1'b0, 1'b0);
        end
        checks++; if (bus_s.err_cnt_o !== 4'd15) begin errors++; $display("FAIL sat_err_s: got %0d expected 15", bus_s.err_cnt_o); end
        checks++; if (bus.err_cnt_o !== 16'd40) begin errors++; $display("FAIL sat_err: got %0d expected 40", bus.err_cnt_o); end
        checks++; if (bus_s.err_flag_o !== 1'b1) begin errors++; $display("FAIL sat_flag_s: got %0b expected 1", bus_s.err_flag_o); end
    endtask

    task automatic test_scan_enable();
        bus.pmt_scan_en_i = 1'b0;
        pulse(1, 3, 1);
        checks++; if (bus.pulse_cnt_o !== 16'd20) begin errors++; $display("FAIL scanoff_pulse_hold: got %0d expected 20", bus.pulse_cnt_o); end
        checks++; if (bus.err_cnt_o !== 16'd40) begin errors++; $display("FAIL scanoff_err_hold: got %0d expected 40", bus.err_cnt_o); end
        bus.pmt_scan_en_i = 1'b1;
        drive(1'b1, 1'b0);
        checks++; if (bus.pulse_cnt_o !== 16'd0) begin errors++; $display("FAIL scanon_pulse: got %0d expected 0", bus.pulse_cnt_o); end
        checks++; if (bus.err_cnt_o !== 16'd0) begin errors++; $display("FAIL scanon_err: got %0d expected 0", bus.err_cnt_o); end
        checks++; if (bus.err_flag_o !== 1'b0) begin errors++; $display("FAIL scanon_flag: got %0b expected 0", bus.err_flag_o); end
        checks++; if (bus.pose_delay_o !== 16'd0) begin errors++; $display("FAIL scanon_pose: got %0d expected 0", bus.pose_delay_o); end
        // ctrl rise was in the enable cycle, so the later flag rise is spurious
        set_exp(1, 2);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        checks++; if (bus.err_cnt_o !== 16'd1) begin errors++; $display("FAIL ignored_edge_err: got %0d expected 1", bus.err_cnt_o); end
        checks++; if (bus.nege_delay_o !== 16'd2) begin errors++; $display("FAIL ignored_edge_nege: got %0d expected 2", bus.nege_delay_o); end
        checks++; if (bus.pose_delay_o !== 16'd0) begin errors++; $display("FAIL ignored_edge_pose: got %0d expected 0", bus.pose_delay_o); end
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        bus.pmt_scan_en_i = 1'b0;
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        checks++; if (bus.err_cnt_o !== 16'd1) begin errors++; $display("FAIL abandon_err: got %0d expected 1", bus.err_cnt_o); end
        bus.pmt_scan_en_i = 1'b1;
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        checks++; if (bus.nege_delay_o !== 16'd1) begin errors++; $display("FAIL reen_nege: got %0d expected 1", bus.nege_delay_o); end
        checks++; if (bus.err_cnt_o !== 16'd0) begin errors++; $display("FAIL reen_err: got %0d expected 0", bus.err_cnt_o); end
        checks++; if (bus.pulse_cnt_o !== 16'd1) begin errors++; $display("FAIL reen_pulse: got %0d expected 1", bus.pulse_cnt_o); end
    endtask

    task automatic test_reset_mid();
        set_exp(3, 2);
        pulse(3, 5, 2);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        #3 rst = 1'b1;
        #1;
        checks++; if (bus.pulse_cnt_o !== 16'd0) begin errors++; $display("FAIL rstmid_pulse: got %0d expected 0", bus.pulse_cnt_o); end
        checks++; if (bus.pose_delay_o !== 16'd0) begin errors++; $display("FAIL rstmid_pose: got %0d expected 0", bus.pose_delay_o); end
        checks++; if (bus.nege_delay_o !== 16'd0) begin errors++; $display("FAIL rstmid_nege: got %0d expected 0", bus.nege_delay_o); end
        checks++; if (bus_s.pulse_cnt_o !== 4'd0) begin errors++; $display("FAIL rstmid_pulse_s: got %0d expected 0", bus_s.pulse_cnt_o); end
        #2 rst = 1'b0;
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
    endtask

    task automatic test_random();
        int ep, en, h, dp, dn, mv0;
        int pc = 0;
        int ec = 0;
        scan_restart();
        for (int i = 0; i < 40; i++) begin
            ep = int'($urandom_range(0, 12));
            en = int'($urandom_range(0, 12));
            h  = int'($urandom_range(1, 10));
            dp = int'($urandom_range(0, h));
            dn = int'($urandom_range(0, 8));
            if (dp == h && dn == 0) dn = 1;
            set_exp(ep, en);
            mv0 = mv_cnt;
            pulse(dp, h, dn);
            pc++;
            ec += (absd(dp, ep) > 2 ? 1 : 0) + (absd(dn, en) > 2 ? 1 : 0);
            checks++; if (bus.pose_delay_o !== 16'(dp)) begin errors++; $display("FAIL rnd_pose[%0d]: got %0d expected %0d", i, bus.pose_delay_o, dp); end
            checks++; if (bus.nege_delay_o !== 16'(dn)) begin errors++; $display("FAIL rnd_nege[%0d]: got %0d expected %0d", i, bus.nege_delay_o, dn); end
            checks++; if (bus.pulse_cnt_o !== 16'(pc)) begin errors++; $display("FAIL rnd_pulse[%0d]: got %0d expected %0d", i, bus.pulse_cnt_o, pc); end
            checks++; if (bus.err_cnt_o !== 16'(ec)) begin errors++; $display("FAIL rnd_err[%0d]: got %0d expected %0d", i, bus.err_cnt_o, ec); end
            checks++; if (bus.err_flag_o !== logic'(ec > 0)) begin errors++; $display("FAIL rnd_flag[%0d]: got %0b expected %0b", i, bus.err_flag_o, ec > 0); end
            checks++; if (mv_cnt - mv0 !== 1) begin errors++; $display("FAIL rnd_valid[%0d]: got %0d expected 1", i, mv_cnt - mv0); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.pmt_scan_en_i        = 1'b0;
        bus.acc_demo_trim_ctrl_i = 1'b0;
        bus.acc_demo_trim_flag_i = 1'b0;
        set_exp(0, 0);
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_nominal();
        test_tolerance();
        test_same_cycle();
        test_spurious_and_restart();
        test_timeout();
        test_saturation();
        test_scan_enable();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
